// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter/receiver pair: FSM state encoding,
// parity mode codes and line-timing helpers.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        PAR   = 3'd3,
        STOP  = 3'd4
    } uart_state_t;

    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_ODD  = 2'd1;
    localparam logic [1:0] PAR_EVEN = 2'd2;

    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

    // data_xor is the XOR-reduction of the data bits; returns 1 on a mismatch
    function automatic logic parity_bad(input logic data_xor, input logic par_bit,
                                        input logic [1:0] mode);
        logic bad_s;
        case (mode)
            PAR_ODD:  bad_s = ~(data_xor ^ par_bit);
            PAR_EVEN: bad_s = data_xor ^ par_bit;
            default:  bad_s = 1'b0;
        endcase
        return bad_s;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: wraps every CPB cycles, or every CPB/2 cycles while 'half'
// is set (start-bit centring). 'load' holds it at zero.
module uart_baud_cnt
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 9600
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic half,
    output logic tick
);

    localparam int CPB = clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int CW  = (CPB > 1) ? $clog2(CPB) : 1;
    localparam logic [CW-1:0] FULL_TERM = CW'(CPB - 1);
    localparam logic [CW-1:0] HALF_TERM = CW'(CPB / 2 - 1);

    logic [CW-1:0] cnt_r;
    logic [CW-1:0] term_s;

    // Terminal count select and wrap decode
    always_comb begin
        term_s = FULL_TERM;
        if (half) begin
            term_s = HALF_TERM;
        end else begin
            term_s = FULL_TERM;
        end
        tick = (cnt_r == term_s);
    end

    // Free-running count, cleared on load or on wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= {CW{1'b0}};
        end else if (load || tick) begin
            cnt_r <= {CW{1'b0}};
        end else begin
            cnt_r <= cnt_r + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronises rx, samples each bit at mid-bit and commits the frame
// into a single holding register with valid/read handshake and error flags.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int STOP_BIT   = 1,
    parameter int PARITY     = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  rx_valid,
    output logic                  rx_done,
    output logic                  parity_err,
    output logic                  frame_err,
    output logic                  overrun
);

    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_WIDTH - 1);
    localparam logic          LAST_STOP = 1'(STOP_BIT - 1);
    localparam logic [1:0]    PAR_MODE  = 2'(PARITY);

    logic [1:0]            sync_r;
    logic                  rx_s;
    uart_state_t           state_r;
    logic [DATA_WIDTH-1:0] shift_r;
    logic [BW-1:0]         bit_cnt_r;
    logic                  stop_cnt_r;
    logic                  par_err_r;
    logic                  frm_err_r;
    logic                  tick_s;

    // Two-flop synchroniser, idles high so reset never looks like a start bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_r <= 2'b11;
        end else begin
            sync_r <= {sync_r[0], rx};
        end
    end

    assign rx_s = sync_r[1];

    uart_baud_cnt #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD_RATE (BAUD_RATE)
    ) u_baud (
        .clk  (clk),
        .rst  (rst),
        .load (state_r == IDLE),
        .half (state_r == START),
        .tick (tick_s)
    );

    // Frame FSM with the holding register and flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            shift_r    <= {DATA_WIDTH{1'b0}};
            bit_cnt_r  <= {BW{1'b0}};
            stop_cnt_r <= 1'b0;
            par_err_r  <= 1'b0;
            frm_err_r  <= 1'b0;
            dout       <= {DATA_WIDTH{1'b0}};
            rx_valid   <= 1'b0;
            rx_done    <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            rx_done <= 1'b0;
            if (rd_en && rx_valid) begin
                rx_valid <= 1'b0;
            end else begin
                rx_valid <= rx_valid;
            end

            case (state_r)
                IDLE: begin
                    bit_cnt_r  <= {BW{1'b0}};
                    stop_cnt_r <= 1'b0;
                    par_err_r  <= 1'b0;
                    frm_err_r  <= 1'b0;
                    if (!rx_s) begin
                        state_r <= START;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                START: begin
                    if (tick_s) begin
                        // A start bit that is high again at mid-bit was a glitch
                        state_r <= rx_s ? IDLE : DATA;
                    end else begin
                        state_r <= START;
                    end
                end
                DATA: begin
                    if (tick_s) begin
                        shift_r <= {rx_s, shift_r[DATA_WIDTH-1:1]};
                        if (bit_cnt_r == LAST_BIT) begin
                            bit_cnt_r <= {BW{1'b0}};
                            state_r   <= (PAR_MODE != PAR_NONE) ? PAR : STOP;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 1'b1;
                        end
                    end else begin
                        state_r <= DATA;
                    end
                end
                PAR: begin
                    if (tick_s) begin
                        par_err_r <= parity_bad(^shift_r, rx_s, PAR_MODE);
                        state_r   <= STOP;
                    end else begin
                        state_r <= PAR;
                    end
                end
                STOP: begin
                    if (tick_s) begin
                        if (stop_cnt_r == LAST_STOP) begin
                            dout       <= shift_r;
                            rx_done    <= 1'b1;
                            rx_valid   <= 1'b1;
                            parity_err <= par_err_r;
                            frame_err  <= frm_err_r | ~rx_s;
                            overrun    <= rx_valid & ~rd_en;
                            state_r    <= IDLE;
                        end else begin
                            stop_cnt_r <= stop_cnt_r + 1'b1;
                            frm_err_r  <= frm_err_r | ~rx_s;
                        end
                    end else begin
                        state_r <= STOP;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule
